// File: rtl/bypass_scoreboard_unit_pkg.sv
// rtl/bypass_scoreboard_unit_pkg.sv - shared constants and bus-width helpers for the bypass scoreboard
package bypass_scoreboard_unit_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int STG_EXE = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Width of a flattened bus carrying n fields of w bits each
  function automatic int bus_w(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/bypass_port_select.sv
// rtl/bypass_port_select.sv - per-read-port bypass source selection with scoreboard fallback
module bypass_port_select
  import bypass_scoreboard_unit_pkg::*;
#(
  parameter int NUM_STG = 3,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic [NUM_STG-1:0]                stg_valid,
  input  logic [NUM_STG-1:0]                stg_wen,
  input  logic [NUM_STG-1:0]                stg_ready,
  input  logic [bus_w(NUM_STG, ADDR_W)-1:0] stg_waddr,
  input  logic [bus_w(NUM_STG, DATA_W)-1:0] stg_wdata,
  input  logic                              rp_en,
  input  logic [ADDR_W-1:0]                 rp_addr,
  input  logic                              pend_bit,
  input  logic                              ll_done,
  input  logic [ADDR_W-1:0]                 ll_done_addr,
  input  logic [DATA_W-1:0]                 ll_done_data,
  output logic                              hit,
  output logic [DATA_W-1:0]                 data,
  output logic                              blocked
);

  logic              found;
  logic              win_ready;
  logic [DATA_W-1:0] win_data;
  logic              active;

  assign active = rp_en && (rp_addr != '0);

  // Scan oldest to youngest so the youngest matching stage is the last assignment
  always_comb begin
    found     = 1'b0;
    win_ready = 1'b0;
    win_data  = '0;
    for (int i = NUM_STG - 1; i >= 0; i--) begin
      if (stg_valid[i] && stg_wen[i] && (stg_waddr[i*ADDR_W +: ADDR_W] == rp_addr)) begin
        found     = 1'b1;
        win_ready = stg_ready[i];
        win_data  = stg_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    data    = '0;
    blocked = 1'b0;
    if (active) begin
      if (found) begin
        if (win_ready) begin
          hit  = 1'b1;
          data = win_data;
        end else begin
          blocked = 1'b1;
        end
      end else if (pend_bit) begin
        if (ll_done && (ll_done_addr == rp_addr)) begin
          hit  = 1'b1;
          data = ll_done_data;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard_unit.sv
// rtl/bypass_scoreboard_unit.sv - bypass network with long-latency scoreboard, stall and perf counters
module bypass_scoreboard_unit
  import bypass_scoreboard_unit_pkg::*;
#(
  parameter int NUM_STG = 3,
  parameter int NUM_RP  = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_STG-1:0]                stg_valid,
  input  logic [NUM_STG-1:0]                stg_wen,
  input  logic [NUM_STG-1:0]                stg_ready,
  input  logic [bus_w(NUM_STG, ADDR_W)-1:0] stg_waddr,
  input  logic [bus_w(NUM_STG, DATA_W)-1:0] stg_wdata,
  input  logic [NUM_RP-1:0]                 rp_en,
  input  logic [bus_w(NUM_RP, ADDR_W)-1:0]  rp_addr,
  output logic [NUM_RP-1:0]                 fwd_hit,
  output logic [bus_w(NUM_RP, DATA_W)-1:0]  fwd_data,
  output logic                              stall,
  input  logic                              ll_issue,
  input  logic [ADDR_W-1:0]                 ll_issue_addr,
  input  logic                              ll_done,
  input  logic [ADDR_W-1:0]                 ll_done_addr,
  input  logic [DATA_W-1:0]                 ll_done_data,
  output logic [(1<<ADDR_W)-1:0]            pending,
  output logic                              waw_err,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic [CNT_W-1:0]                  fwd_cnt
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_RP-1:0]   blocked;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                issue_ok;
  logic                waw_set;

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    bypass_port_select #(
      .NUM_STG(NUM_STG),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_sel (
      .stg_valid   (stg_valid),
      .stg_wen     (stg_wen),
      .stg_ready   (stg_ready),
      .stg_waddr   (stg_waddr),
      .stg_wdata   (stg_wdata),
      .rp_en       (rp_en[p]),
      .rp_addr     (rp_addr[p*ADDR_W +: ADDR_W]),
      .pend_bit    (pending[rp_addr[p*ADDR_W +: ADDR_W]]),
      .ll_done     (ll_done),
      .ll_done_addr(ll_done_addr),
      .ll_done_data(ll_done_data),
      .hit         (fwd_hit[p]),
      .data        (fwd_data[p*DATA_W +: DATA_W]),
      .blocked     (blocked[p])
    );
  end

  assign stall    = |blocked;
  assign issue_ok = ll_issue && !stall;
  assign waw_set  = issue_ok && pending[ll_issue_addr] &&
                    !(ll_done && (ll_done_addr == ll_issue_addr));

  // Clear first, then set, so a same-address issue overrides the returning result
  always_comb begin
    pending_nxt = pending;
    if (ll_done) begin
      pending_nxt[ll_done_addr] = 1'b0;
    end
    if (issue_ok && (ll_issue_addr != '0)) begin
      pending_nxt[ll_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      waw_err   <= 1'b0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (cnt_clr) begin
      waw_err   <= 1'b0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (waw_set) begin
        waw_err <= 1'b1;
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((|fwd_hit) && (fwd_cnt != {CNT_W{1'b1}})) begin
        fwd_cnt <= fwd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bypass_scoreboard_unit.sv
// tb/tb_bypass_scoreboard_unit.sv - self-checking bench for bypass_scoreboard_unit
module tb_bypass_scoreboard_unit;

  localparam int NS = 3;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 10;
  localparam int NREG = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NS-1:0]     stg_valid, stg_wen, stg_ready;
  logic [NS*AW-1:0]  stg_waddr;
  logic [NS*DW-1:0]  stg_wdata;
  logic [NR-1:0]     rp_en;
  logic [NR*AW-1:0]  rp_addr;
  logic [NR-1:0]     fwd_hit;
  logic [NR*DW-1:0]  fwd_data;
  logic              stall;
  logic              ll_issue, ll_done, cnt_clr;
  logic [AW-1:0]     ll_issue_addr, ll_done_addr;
  logic [DW-1:0]     ll_done_data;
  logic [NREG-1:0]   pending;
  logic              waw_err;
  logic [CW-1:0]     stall_cnt, fwd_cnt;

  int checks = 0;
  int errors = 0;

  bit [NREG-1:0] m_pend;
  bit            m_waw;
  int            m_sc, m_fc;

  always #5 clk = ~clk;

  bypass_scoreboard_unit #(
    .NUM_STG(NS), .NUM_RP(NR), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .stg_valid(stg_valid), .stg_wen(stg_wen), .stg_ready(stg_ready),
    .stg_waddr(stg_waddr), .stg_wdata(stg_wdata),
    .rp_en(rp_en), .rp_addr(rp_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall(stall),
    .ll_issue(ll_issue), .ll_issue_addr(ll_issue_addr),
    .ll_done(ll_done), .ll_done_addr(ll_done_addr), .ll_done_data(ll_done_data),
    .pending(pending), .waw_err(waw_err),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stg_valid = '0; stg_wen = '0; stg_ready = '1; stg_waddr = '0; stg_wdata = '0;
    rp_en = '0; rp_addr = '0;
    ll_issue = 0; ll_issue_addr = '0; ll_done = 0; ll_done_addr = '0; ll_done_data = '0;
    cnt_clr = 0;
  endtask

  task automatic set_stg(input int i, input logic v, input logic r, input int a, input logic [DW-1:0] d);
    stg_valid[i] = v; stg_wen[i] = v; stg_ready[i] = r;
    stg_waddr[i*AW +: AW] = AW'(a); stg_wdata[i*DW +: DW] = d;
  endtask

  task automatic set_rp(input int p, input logic en, input int a);
    rp_en[p] = en; rp_addr[p*AW +: AW] = AW'(a);
  endtask

  // First matching stage from youngest upward decides; otherwise the scoreboard may
  function automatic void model_port(input int p, output bit hit, output logic [DW-1:0] d, output bit blk);
    logic [AW-1:0] a;
    a = rp_addr[p*AW +: AW];
    hit = 0; d = '0; blk = 0;
    if (!rp_en[p] || a == 0) return;
    for (int i = 0; i < NS; i++) begin
      if (stg_valid[i] && stg_wen[i] && stg_waddr[i*AW +: AW] == a) begin
        if (stg_ready[i]) begin hit = 1; d = stg_wdata[i*DW +: DW]; end
        else blk = 1;
        return;
      end
    end
    if (m_pend[a]) begin
      if (ll_done && ll_done_addr == a) begin hit = 1; d = ll_done_data; end
      else blk = 1;
    end
  endfunction

  function automatic void model_edge(input bit stl, input bit fwd);
    bit iss;
    iss = ll_issue && !stl;
    if (cnt_clr) begin
      m_waw = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (iss && m_pend[ll_issue_addr] && !(ll_done && ll_done_addr == ll_issue_addr)) m_waw = 1;
      if (stl && m_sc < CMAX) m_sc++;
      if (fwd && m_fc < CMAX) m_fc++;
    end
    if (ll_done) m_pend[ll_done_addr] = 0;
    if (iss && ll_issue_addr != 0) m_pend[ll_issue_addr] = 1;
  endfunction

  task automatic cycle();
    logic [NR-1:0]    eh;
    logic [NR*DW-1:0] ed;
    bit               eb, h, b;
    logic [DW-1:0]    d;
    #1;
    eh = '0; ed = '0; eb = 0;
    for (int p = 0; p < NR; p++) begin
      model_port(p, h, d, b);
      eh[p] = h; ed[p*DW +: DW] = d; eb = eb | b;
    end
    chk("fwd_hit", 64'(fwd_hit), 64'(eh));
    chk("fwd_data", 64'(fwd_data), 64'(ed));
    chk("stall", 64'(stall), 64'(eb));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("waw_err", 64'(waw_err), 64'(m_waw));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    chk("fwd_cnt", 64'(fwd_cnt), 64'(m_fc));
    @(posedge clk);
    model_edge(eb, |eh);
    @(negedge clk);
  endtask

  initial begin
    idle();
    resetn = 0;
    m_pend = '0; m_waw = 0; m_sc = 0; m_fc = 0;
    repeat (2) @(negedge clk);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_cnts", 64'({waw_err, stall_cnt, fwd_cnt}), 64'd0);
    resetn = 1;

    // EXE and MEM both write r5; youngest wins
    set_stg(0, 1, 1, 5, 32'h11); set_stg(1, 1, 1, 5, 32'h22); set_rp(0, 1, 5);
    #1;
    chk("t1_hit", 64'(fwd_hit[0]), 64'd1);
    chk("t1_data", 64'(fwd_data[31:0]), 64'h11);
    chk("t1_stall", 64'(stall), 64'd0);
    cycle();
    chk("t1_fwd_cnt", 64'(fwd_cnt), 64'd1);

    // EXE load not ready shadows the ready MEM value
    idle();
    set_stg(0, 1, 0, 7, 32'h0); set_stg(1, 1, 1, 7, 32'h33); set_rp(1, 1, 7);
    #1;
    chk("t2_stall", 64'(stall), 64'd1);
    chk("t2_hit", 64'(fwd_hit[1]), 64'd0);
    cycle();
    set_stg(0, 1, 1, 7, 32'h44);
    #1;
    chk("t2b_data", 64'(fwd_data[63:32]), 64'h44);
    chk("t2b_stall", 64'(stall), 64'd0);
    cycle();

    // Long-latency r9: stall until the result returns
    idle();
    ll_issue = 1; ll_issue_addr = 9; cnt_clr = 1;
    cycle();
    idle();
    set_rp(0, 1, 9);
    repeat (4) cycle();
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd4);
    ll_done = 1; ll_done_addr = 9; ll_done_data = 32'hDEAD;
    #1;
    chk("t3_hit", 64'(fwd_hit[0]), 64'd1);
    chk("t3_data", 64'(fwd_data[31:0]), 64'hDEAD);
    chk("t3_stall", 64'(stall), 64'd0);
    cycle();
    chk("t3_pend9", 64'(pending[9]), 64'd0);

    // r0 never forwards and never gets a pending bit
    idle();
    set_stg(0, 1, 1, 0, 32'hFF); set_rp(0, 1, 0); set_rp(1, 1, 0);
    ll_issue = 1; ll_issue_addr = 0;
    cycle();
    chk("t4_pending", 64'(pending), 64'd0);

    // Write-after-write on r3, then a same-cycle done+issue
    idle();
    ll_issue = 1; ll_issue_addr = 3;
    cycle();
    cycle();
    chk("t5_waw", 64'(waw_err), 64'd1);
    idle(); cnt_clr = 1;
    cycle();
    chk("t5_clr", 64'(waw_err), 64'd0);
    idle();
    ll_issue = 1; ll_issue_addr = 3; ll_done = 1; ll_done_addr = 3;
    cycle();
    chk("t5_pend3", 64'(pending[3]), 64'd1);
    chk("t5_nowaw", 64'(waw_err), 64'd0);

    // Randomized traffic over a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++)
        set_stg(i, 1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 6), $urandom);
      stg_wen = NS'($urandom);
      for (int p = 0; p < NR; p++) set_rp(p, 1'($urandom), $urandom_range(0, 6));
      ll_issue = ($urandom_range(0, 3) == 0); ll_issue_addr = AW'($urandom_range(0, 6));
      ll_done = ($urandom_range(0, 2) == 0); ll_done_addr = AW'($urandom_range(0, 6));
      ll_done_data = $urandom;
      cnt_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    // Saturate the stall counter
    idle(); cnt_clr = 1;
    cycle();
    idle();
    set_stg(0, 1, 0, 1, 32'h0); set_rp(0, 1, 1);
    repeat (CMAX + 6) cycle();
    chk("t6_sat", 64'(stall_cnt), 64'(CMAX));

    // Asynchronous reset with pending bits set
    idle();
    ll_issue = 1; ll_issue_addr = 12;
    cycle();
    idle();
    chk("t7_pend12", 64'(pending[12]), 64'd1);
    #2 resetn = 0;
    #1;
    chk("t7_pending", 64'(pending), 64'd0);
    chk("t7_cnts", 64'({waw_err, stall_cnt, fwd_cnt}), 64'd0);
    m_pend = '0; m_waw = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    resetn = 1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bypass_scoreboard_unit.md
Name: bypass_scoreboard_unit

Overview:
Parametrised successor to the fixed three-stage bypass network. It accepts write-back info from NUM_STG post-decode stages and serves NUM_RP decode read ports with forwarded data. It adds a register scoreboard for long-latency (multi-cycle) writers, load-use/scoreboard stall generation, and saturating performance counters. It sits between the EXE/MEM/WB stage buses and the ID stage.

Parameters:
NUM_STG, 3, number of forwarding source stages; index 0 = youngest (EXE), NUM_STG-1 = oldest (WB)
NUM_RP, 2, number of decode register read ports
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers; register 0 hard-wired zero)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
stg_valid  in  NUM_STG  stage holds a valid instruction
stg_wen  in  NUM_STG  stage instruction writes a register
stg_ready  in  NUM_STG  stage write data is final (0 = load result not yet available)
stg_waddr  in  NUM_STG*ADDR_W  destination per stage, stage i at [i*ADDR_W +: ADDR_W]
stg_wdata  in  NUM_STG*DATA_W  write data per stage
rp_en  in  NUM_RP  read port in use
rp_addr  in  NUM_RP*ADDR_W  read address per port
fwd_hit  out  NUM_RP  port data comes from bypass, not register file
fwd_data  out  NUM_RP*DATA_W  forwarded data per port
stall  out  1  ID must hold this cycle
ll_issue  in  1  long-latency op leaves ID this cycle (ignored while stall=1)
ll_issue_addr  in  ADDR_W  its destination
ll_done  in  1  long-latency result returns this cycle
ll_done_addr  in  ADDR_W  returning destination
ll_done_data  in  DATA_W  returning data
pending  out  2**ADDR_W  registered scoreboard bitmap
waw_err  out  1  sticky: issue to an already-pending register
cnt_clr  in  1  synchronous clear of counters and waw_err
stall_cnt  out  CNT_W  cycles with stall=1, saturating
fwd_cnt  out  CNT_W  cycles with any fwd_hit=1, saturating

Behaviour:
- Reset (resetn=0, async): pending=0, waw_err=0, stall_cnt=0, fwd_cnt=0. Combinational outputs follow inputs.
- Stage match i for port p: stg_valid[i] & stg_wen[i] & waddr_i==rp_addr_p & rp_addr_p!=0 & rp_en[p].
- Priority: youngest matching stage wins (lowest index). Older stages are not consulted once a match is found.
- If the winning stage has stg_ready=0: port is blocked, fwd_hit=0, fwd_data=0.
- If no stage matches and pending[rp_addr_p]=1:
  - ll_done with equal ll_done_addr this cycle -> hit, data=ll_done_data.
  - Otherwise port blocked.
- No match at all -> fwd_hit=0, fwd_data=0. The register file supplies the value.
- rp_addr=0 or rp_en=0 -> never hit, never blocks.
- stall = OR of blocked ports. Combinational, zero latency.
- Scoreboard update (posedge):
  - ll_done clears the done bit.
  - ll_issue & !stall sets the issue bit.
  - If both target the same address, the bit ends set (issue wins).
  - Address 0 is never set.
- waw_err sets when ll_issue & !stall & pending[ll_issue_addr] & !(ll_done & ll_done_addr==ll_issue_addr). It stays set until cnt_clr or reset.
- Counters increment by 1 per qualifying cycle and hold at all-ones. cnt_clr forces 0 that edge; clear wins over increment.
- Pending bits survive pipeline flushes. Outstanding long ops always complete.

Decomposition:
- Shared package/header: ADDR_W/DATA_W defaults, stage index constants (STG_EXE=0, STG_MEM=1, STG_WB=2), bus-width macros for the flattened stage and port buses.
- One sub-module: bypass_port_select, instantiated once per read port. It implements per-port priority match, ready check and scoreboard fallback, and outputs hit/data/blocked.
- Scoreboard and counters live in the top module.

Test Plan:
- EXE and MEM both write r5 (0x11, 0x22), all ready, rp0 reads r5 -> fwd_hit[0]=1, data=0x11, stall=0, fwd_cnt +1.
- EXE load to r7 with stg_ready[0]=0, MEM writes r7=0x33, rp1 reads r7 -> stall=1, fwd_hit[1]=0. Next cycle with stg_ready[0]=1, data 0x44 -> hit, data=0x44, stall=0.
- ll_issue r9, then rp0 reads r9 for 4 cycles -> stall=1 each cycle, stall_cnt=4. ll_done r9 data 0xDEAD the same cycle as the read -> hit, 0xDEAD, stall=0. pending[9]=0 next cycle.
- rp reads r0 while EXE writes r0=0xFF -> fwd_hit=0, fwd_data=0, stall=0. ll_issue to r0 -> pending unchanged.
- ll_issue r3 twice without done -> waw_err=1. Same-cycle ll_done r3 + ll_issue r3 -> pending[3]=1, no error. cnt_clr -> waw_err=0.
- Drive stall for 2**CNT_W+5 cycles -> stall_cnt saturates at all-ones. Assert resetn=0 mid-run with pending bits set -> all pending and counters 0 immediately, without waiting for clk.
